// File: rtl/option22_pkg.sv
// option22_pkg: shared constants, address-width helper and ring position type for option22 blocks.
package option22_pkg;
  localparam int WORD_COUNT_DEF = 64;
  localparam int BITS_PER_WORD = 8;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int RING_ADDR_W = addr_w(WORD_COUNT_DEF);
  typedef struct packed {
    logic [RING_ADDR_W-1:0] slot;
    logic [2:0]             bit_phase;
  } ring_pos_t;
endpackage

// File: rtl/option22_if.sv
// option22_if: host write request handshake (valid/ready with slot address and byte).
interface option22_if
  import option22_pkg::*;
#(
  parameter int ADDR_W = RING_ADDR_W
);
  logic                     wr_valid;
  logic                     wr_ready;
  logic [ADDR_W-1:0]        wr_addr;
  logic [BITS_PER_WORD-1:0] wr_data;
  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/option22_ring_phase.sv
// option22_ring_phase: bit/slot counters mirroring the ring memory; frame_start marks the edge that begins a frame.
module option22_ring_phase
  import option22_pkg::*;
#(
  parameter int WORD_COUNT = WORD_COUNT_DEF,
  parameter int ADDR_W = addr_w(WORD_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] slot,
  output logic [2:0]        bit_phase,
  output logic              frame_start,
  output logic [ADDR_W-1:0] next_slot
);
  assign frame_start = bit_phase == 3'd7;
  assign next_slot = slot + ADDR_W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bit_phase <= '0;
      slot <= '0;
    end else begin
      bit_phase <= bit_phase + 3'd1;
      if (frame_start) slot <= next_slot;
    end
endmodule

// File: rtl/option22_writer.sv
// option22_writer: accepts (slot, byte) writes and shifts each byte MSB first into the
// ring during the 8-cycle frame that belongs to its slot.
module option22_writer
  import option22_pkg::*;
#(
  parameter int WORD_COUNT = WORD_COUNT_DEF,
  parameter int ADDR_W = addr_w(WORD_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  option22_if.slave         wr,
  output logic              write,
  output logic              din,
  output logic [ADDR_W-1:0] slot,
  output logic [2:0]        bit_phase,
  output logic              busy
);
  logic                     frame_start, accept, launch, pend_valid, act;
  logic [ADDR_W-1:0]        next_slot, pend_addr;
  logic [BITS_PER_WORD-1:0] pend_data, launch_data, sh;
  option22_ring_phase #(.WORD_COUNT(WORD_COUNT), .ADDR_W(ADDR_W)) u_phase (
    .clk(clk),
    .reset(reset),
    .slot(slot),
    .bit_phase(bit_phase),
    .frame_start(frame_start),
    .next_slot(next_slot)
  );
  assign wr.wr_ready = !pend_valid;
  assign accept = wr.wr_valid && wr.wr_ready;
  // A request accepted on the boundary edge itself bypasses the holding stage for zero wait.
  assign launch = frame_start && (pend_valid ? pend_addr == next_slot : accept && wr.wr_addr == next_slot);
  assign launch_data = pend_valid ? pend_data : wr.wr_data;
  assign write = act;
  assign busy = pend_valid || act;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      act <= 1'b0;
      sh <= '0;
      din <= 1'b0;
    end else begin
      pend_valid <= (pend_valid || accept) && !launch;
      if (accept) begin
        pend_addr <= wr.wr_addr;
        pend_data <= wr.wr_data;
      end
      if (frame_start) begin
        act <= launch;
        din <= launch && launch_data[7];
        sh <= {launch_data[6:0], 1'b0};
      end else begin
        din <= act && sh[7];
        sh <= {sh[6:0], 1'b0};
      end
    end
endmodule
